// File: rtl/multiplier_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : multiplier_pkg                                                 |
// | Purpose : Shared types and helpers for the shift-and-add multiplier      |
// |           sequencer: the FSM state encoding and the shift-counter width  |
// |           helper.                                                        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package multiplier_pkg;

  // Sequencer states, two-bit explicit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Shift-counter width: wide enough to hold N, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : multiplier_pkg
`default_nettype wire

// File: rtl/multiplier_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : multiplier_control                                             |
// | Purpose : Sequencing front end for the shift-and-add multiplier          |
// |           datapath. Accepts an operand pair over valid/ready, holds it   |
// |           stable on dp_multiplicand/dp_multiplier, pulses do_init for    |
// |           one cycle, then do_shift for N cycles, and presents the        |
// |           datapath product on a valid/ready result port.                 |
// | Ports   : clock, reset           - clock, synchronous active-high reset  |
// |           in_valid/in_ready      - operand handshake                     |
// |           in_multiplicand [N]    - multiplicand operand                  |
// |           in_multiplier   [N]    - multiplier operand                    |
// |           out_valid/out_ready    - result handshake                      |
// |           out_product     [2N]   - unsigned product (0 outside DONE)     |
// |           do_init, do_shift      - datapath strobes                      |
// |           dp_multiplicand [N]    - held multiplicand to datapath         |
// |           dp_multiplier   [N]    - held multiplier to datapath           |
// |           dp_product      [2N]   - product from datapath                 |
// | Options : MULT_CTRL_ZERO_SKIP_EN - a zero multiplier skips all SHIFT     |
// |           cycles (INIT goes straight to DONE).                           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module multiplier_control
  import multiplier_pkg::*;
#(
  parameter int N = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_multiplicand,
  input  logic [N-1:0]     in_multiplier,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_product,
  output logic             do_init,
  output logic             do_shift,
  output logic [N-1:0]     dp_multiplicand,
  output logic [N-1:0]     dp_multiplier,
  input  logic [2*N-1:0]   dp_product
);

  localparam int            CW         = cnt_width(N);
  // Counter counts N-1 down to 0 inclusive, giving exactly N SHIFT cycles.
  localparam logic [CW-1:0] C_CNT_LOAD = CW'(N - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          do_init_q, do_init_d;
  logic          do_shift_q, do_shift_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mcand_d  = in_multiplicand;
          mplier_d = in_multiplier;
          state_d  = INIT;
        end
      end
      INIT: begin
        cnt_d   = C_CNT_LOAD;
        state_d = SHIFT;
`ifdef MULT_CTRL_ZERO_SKIP_EN
        // do_init already cleared a and q, so the product is final.
        if (mplier_q == '0) begin
          state_d = DONE;
        end
`endif
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so that the registered copy
    // lines up with the state the FSM is in during the following cycle.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    do_init_d   = (state_d == INIT);
    do_shift_d  = (state_d == SHIFT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      do_init_q   <= 1'b0;
      do_shift_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      do_init_q   <= do_init_d;
      do_shift_q  <= do_shift_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign do_init         = do_init_q;
  assign do_shift        = do_shift_q;
  assign dp_multiplicand = mcand_q;
  assign dp_multiplier   = mplier_q;
  // The datapath holds its product while both strobes are low, so passing
  // it straight through during DONE is stable; elsewhere it is masked.
  assign out_product     = out_valid_q ? dp_product : '0;

endmodule : multiplier_control
`default_nettype wire

// File: tb/tb_multiplier_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_multiplier_control                                          |
// | Purpose : Directed self-checking bench for multiplier_control. Two       |
// |           instances (N=4 and N=8), each driving a behavioural            |
// |           shift-and-add datapath model.                                  |
// | Options : MULT_CTRL_ZERO_SKIP_EN changes the expected zero-multiplier    |
// |           latency.                                                       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_multiplier_control;

`ifdef MULT_CTRL_ZERO_SKIP_EN
  localparam int C_ZLAT   = 2;
  localparam int C_ZSHIFT = 0;
`else
  localparam int C_ZLAT   = 6;
  localparam int C_ZSHIFT = 4;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // ---------------- N = 4 instance ----------------
  logic       in_valid4, in_ready4, out_valid4, out_ready4, do_init4, do_shift4;
  logic [3:0] mc4, mp4, dpmc4, dpmp4;
  logic [7:0] prod4, dpprod4;
  logic [3:0] a4, q4;
  logic [4:0] sum4;

  multiplier_control #(.N(4)) u_dut4 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_multiplicand(mc4), .in_multiplier(mp4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_product(prod4),
    .do_init(do_init4), .do_shift(do_shift4),
    .dp_multiplicand(dpmc4), .dp_multiplier(dpmp4), .dp_product(dpprod4)
  );

  // Datapath model; its active-low reset is tied to ~reset.
  assign sum4    = {1'b0, a4} + (q4[0] ? {1'b0, dpmc4} : 5'd0);
  assign dpprod4 = {a4, q4};
  always @(posedge clock) begin
    if (!(~reset)) begin
      a4 <= '0; q4 <= '0;
    end else if (do_init4) begin
      a4 <= '0; q4 <= dpmp4;
    end else if (do_shift4) begin
      a4 <= sum4[4:1];
      q4 <= {sum4[0], q4[3:1]};
    end
  end

  // ---------------- N = 8 instance ----------------
  logic        in_valid8, in_ready8, out_valid8, out_ready8, do_init8, do_shift8;
  logic [7:0]  mc8, mp8, dpmc8, dpmp8;
  logic [15:0] prod8, dpprod8;
  logic [7:0]  a8, q8;
  logic [8:0]  sum8;

  multiplier_control #(.N(8)) u_dut8 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_multiplicand(mc8), .in_multiplier(mp8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_product(prod8),
    .do_init(do_init8), .do_shift(do_shift8),
    .dp_multiplicand(dpmc8), .dp_multiplier(dpmp8), .dp_product(dpprod8)
  );

  assign sum8    = {1'b0, a8} + (q8[0] ? {1'b0, dpmc8} : 9'd0);
  assign dpprod8 = {a8, q8};
  always @(posedge clock) begin
    if (!(~reset)) begin
      a8 <= '0; q8 <= '0;
    end else if (do_init8) begin
      a8 <= '0; q8 <= dpmp8;
    end else if (do_shift8) begin
      a8 <= sum8[8:1];
      q8 <= {sum8[0], q8[7:1]};
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one operation on the N=4 instance with out_ready=1. lat is the
  // cycle index (acceptance edge = 0) in which out_valid is first seen.
  task automatic run_op4(input logic [3:0] m, input logic [3:0] r,
                         output int lat, output int shifts, output logic [7:0] p);
    in_valid4 = 1'b1; mc4 = m; mp4 = r;
    step();
    in_valid4 = 1'b0;
    lat = 1; shifts = 0;
    while (!out_valid4 && lat < 40) begin
      if (do_shift4) shifts++;
      step();
      lat++;
    end
    p = prod4;
    step();
  endtask

  int          lat, shifts;
  logic [7:0]  p;

  initial begin
    reset = 1'b1;
    in_valid4 = 0; out_ready4 = 1; mc4 = '0; mp4 = '0;
    in_valid8 = 0; out_ready8 = 1; mc8 = '0; mp8 = '0;
    step(); step();

    // Reset state
    chk("rst_in_ready", in_ready4, 1);
    chk("rst_out_valid", out_valid4, 0);
    chk("rst_do_init", do_init4, 0);
    chk("rst_do_shift", do_shift4, 0);
    chk("rst_out_product", prod4, 0);
    chk("rst_dp_mcand", dpmc4, 0);
    chk("rst_dp_mplier", dpmp4, 0);
    chk("rst_in_ready8", in_ready8, 1);
    reset = 1'b0;
    step();

    // 3 x 5, cycle-exact
    in_valid4 = 1; mc4 = 4'd3; mp4 = 4'd5;
    step();                                   // cycle 1
    in_valid4 = 0; mc4 = 4'd9; mp4 = 4'd9;
    chk("t1_c1_do_init", do_init4, 1);
    chk("t1_c1_do_shift", do_shift4, 0);
    chk("t1_c1_in_ready", in_ready4, 0);
    chk("t1_c1_dp_mcand", dpmc4, 3);
    chk("t1_c1_dp_mplier", dpmp4, 5);
    for (int c = 2; c <= 5; c++) begin
      step();
      chk("t1_shift_do_shift", do_shift4, 1);
      chk("t1_shift_do_init", do_init4, 0);
      chk("t1_shift_out_valid", out_valid4, 0);
    end
    step();                                   // cycle 6
    chk("t1_c6_out_valid", out_valid4, 1);
    chk("t1_c6_product", prod4, 15);
    chk("t1_c6_do_shift", do_shift4, 0);
    step();                                   // cycle 7
    chk("t1_c7_in_ready", in_ready4, 1);
    chk("t1_c7_out_valid", out_valid4, 0);
    chk("t1_c7_product_zero", prod4, 0);

    // 15 x 15
    run_op4(4'd15, 4'd15, lat, shifts, p);
    chk("t2_product", p, 225);
    chk("t2_shifts", shifts, 4);
    chk("t2_latency", lat, 6);

    // Backpressure: 7 x 6
    out_ready4 = 0;
    in_valid4 = 1; mc4 = 4'd7; mp4 = 4'd6;
    step();
    in_valid4 = 0;
    lat = 1;
    while (!out_valid4 && lat < 40) begin step(); lat++; end
    chk("t3_latency", lat, 6);
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_product", prod4, 42);
      chk("t3_hold_out_valid", out_valid4, 1);
      chk("t3_hold_in_ready", in_ready4, 0);
      chk("t3_hold_do_shift", do_shift4, 0);
      step();
    end
    chk("t3_final_product", prod4, 42);
    out_ready4 = 1;
    step();
    chk("t3_release_in_ready", in_ready4, 1);
    chk("t3_release_out_valid", out_valid4, 0);

    // Zero multiplier, then zero multiplicand
    run_op4(4'd9, 4'd0, lat, shifts, p);
    chk("t4_zmp_product", p, 0);
    chk("t4_zmp_latency", lat, C_ZLAT);
    chk("t4_zmp_shifts", shifts, C_ZSHIFT);
    run_op4(4'd0, 4'd9, lat, shifts, p);
    chk("t4_zmc_product", p, 0);
    chk("t4_zmc_latency", lat, 6);

    // Reset mid-SHIFT
    in_valid4 = 1; mc4 = 4'd13; mp4 = 4'd11;
    step();                                   // cycle 1
    in_valid4 = 0;
    step();                                   // cycle 2
    step();                                   // cycle 3
    chk("t5_c3_do_shift", do_shift4, 1);
    reset = 1;
    step();                                   // cycle 4
    reset = 0;
    chk("t5_rst_in_ready", in_ready4, 1);
    chk("t5_rst_out_valid", out_valid4, 0);
    chk("t5_rst_do_shift", do_shift4, 0);
    chk("t5_rst_do_init", do_init4, 0);
    chk("t5_rst_dp_mcand", dpmc4, 0);
    run_op4(4'd2, 4'd3, lat, shifts, p);
    chk("t5_after_product", p, 6);
    chk("t5_after_latency", lat, 6);

    // Back-to-back on N=8 with in_valid held high
    in_valid8 = 1; mc8 = 8'd255; mp8 = 8'd255;
    step();                                   // cycle 1 of op A
    mc8 = 8'd128; mp8 = 8'd2;
    chk("t6_a_dp_mcand", dpmc8, 255);
    chk("t6_a_in_ready", in_ready8, 0);
    chk("t6_a_do_init", do_init8, 1);
    lat = 1; shifts = 0;
    while (!out_valid8 && lat < 40) begin
      if (do_shift8) shifts++;
      step(); lat++;
    end
    chk("t6_a_latency", lat, 10);
    chk("t6_a_shifts", shifts, 8);
    chk("t6_a_product", prod8, 65025);
    chk("t6_a_dp_mcand_held", dpmc8, 255);
    step();                                   // IDLE after handshake
    chk("t6_idle_in_ready", in_ready8, 1);
    chk("t6_idle_out_valid", out_valid8, 0);
    step();                                   // cycle 1 of op B
    in_valid8 = 0;
    chk("t6_b_dp_mcand", dpmc8, 128);
    chk("t6_b_dp_mplier", dpmp8, 2);
    chk("t6_b_do_init", do_init8, 1);
    lat = 1;
    while (!out_valid8 && lat < 40) begin step(); lat++; end
    chk("t6_b_latency", lat, 10);
    chk("t6_b_product", prod8, 256);
    step();
    chk("t6_b_done_out_valid", out_valid8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_multiplier_control
`default_nettype wire
